// File: rtl/bbox_scan.sv
// bbox_scan: walks every pixel of an integer bounding box in raster order
// (x fastest, then y) and hands one coordinate per valid/ready handshake to
// the edge-function stage. Ends each box with pix_last on the final pixel,
// a one-cycle done pulse and the number of pixels emitted.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that edge and never retracts valid early; the consumer may
// raise or lower ready freely. bbox_ready is high only in IDLE, and
// bbox_valid/bbox_* are ignored whenever bbox_ready is low.
module bbox_scan #(
  parameter int COORD_W    = 16,
  parameter int SCREEN_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bbox_valid,
  output logic               bbox_ready,
  input  logic [COORD_W-1:0] bbox_x_min,
  input  logic [COORD_W-1:0] bbox_x_max,
  input  logic [COORD_W-1:0] bbox_y_min,
  input  logic [COORD_W-1:0] bbox_y_max,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               done,
  output logic [16:0]        pix_count
);

  localparam logic [COORD_W-1:0] SCREEN_LIM = COORD_W'(SCREEN_MAX);

  // State register is named plainly so checkers can bind to dut.state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;

  // Latched (clamped) bounds of the box being scanned.
  logic [COORD_W-1:0] x_min_q;
  logic [COORD_W-1:0] x_max_q;
  logic [COORD_W-1:0] y_min_q;
  logic [COORD_W-1:0] y_max_q;

  // Clamped view of the incoming box.
  logic [COORD_W-1:0] in_x_min;
  logic [COORD_W-1:0] in_x_max;
  logic [COORD_W-1:0] in_y_min;
  logic [COORD_W-1:0] in_y_max;
  logic               in_empty;

  logic at_x_end;
  logic at_y_end;
  logic pix_fire;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v);
    return (v > SCREEN_LIM) ? SCREEN_LIM : v;
  endfunction

  // Clamp the offered box to the screen and classify it as empty or not.
  always_comb begin
    in_x_min = clamp_coord(bbox_x_min);
    in_x_max = clamp_coord(bbox_x_max);
    in_y_min = clamp_coord(bbox_y_min);
    in_y_max = clamp_coord(bbox_y_max);
    in_empty = (in_x_min > in_x_max) || (in_y_min > in_y_max);
  end

  // Position of the current pixel relative to the latched box edges.
  always_comb begin
    at_x_end = (pix_x == x_max_q);
    at_y_end = (pix_y == y_max_q);
    pix_fire = pix_valid && pix_ready;
    // Gated by pix_valid so it reads 0 out of reset and between boxes.
    pix_last = pix_valid && at_x_end && at_y_end;
  end

  // Scan FSM with registered handshake outputs, coordinates and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bbox_ready <= 1'b1;
      pix_valid  <= 1'b0;
      done       <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_count  <= '0;
      x_min_q    <= '0;
      x_max_q    <= '0;
      y_min_q    <= '0;
      y_max_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bbox_valid) begin
            x_min_q    <= in_x_min;
            x_max_q    <= in_x_max;
            y_min_q    <= in_y_min;
            y_max_q    <= in_y_max;
            pix_count  <= '0;
            bbox_ready <= 1'b0;
            if (in_empty) begin
              // Nothing to emit: report completion straight away.
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_SCAN;
              pix_valid <= 1'b1;
              pix_x     <= in_x_min;
              pix_y     <= in_y_min;
            end
          end
        end

        ST_SCAN: begin
          if (pix_fire) begin
            pix_count <= pix_count + 17'd1;
            if (at_x_end && at_y_end) begin
              // Coordinates are left on the last pixel; only valid drops.
              state     <= ST_DONE;
              pix_valid <= 1'b0;
              done      <= 1'b1;
            end else if (at_x_end) begin
              pix_x <= x_min_q;
              pix_y <= pix_y + COORD_W'(1);
            end else begin
              pix_x <= pix_x + COORD_W'(1);
            end
          end
        end

        ST_DONE: begin
          state      <= ST_IDLE;
          done       <= 1'b0;
          bbox_ready <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          bbox_ready <= 1'b1;
          pix_valid  <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
